// File: rtl/count_event_monitor.sv
// Counter event monitor: detects match entries and wrap/underflow on a counter value, and
// keeps trigger pulses, sticky flags, saturating counts and an arm/capture record.
module count_event_monitor #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_CMP = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TS_W    = 24,
    localparam int unsigned SEL_W  = (NUM_CMP > 1) ? $clog2(NUM_CMP) : 1
) (
    input  logic                       sys_clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           count_in,
    input  logic [NUM_CMP*WIDTH-1:0]   match_val,
    input  logic [NUM_CMP-1:0]         match_en,
    input  logic [NUM_CMP-1:0]         clear_flags,
    input  logic                       arm,
    input  logic [SEL_W-1:0]           cap_sel,
    input  logic                       force_cap,
    output logic [NUM_CMP-1:0]         event_trig,
    output logic [NUM_CMP-1:0]         event_sticky,
    output logic [NUM_CMP*CNT_W-1:0]   event_cnt,
    output logic                       wrap_trig,
    output logic                       under_trig,
    output logic [1:0]                 cap_state,
    output logic [WIDTH-1:0]           cap_val,
    output logic [TS_W-1:0]            cap_time
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StDone  = 2'd2
    } cap_state_e;

    logic [WIDTH-1:0]   r_count_q;
    logic [WIDTH-1:0]   r_count_p;
    logic               r_q_valid;
    logic               r_prev_valid;
    logic [NUM_CMP-1:0] r_trig;
    logic [NUM_CMP-1:0] r_sticky;
    logic [CNT_W-1:0]   r_cnt [NUM_CMP];
    logic               r_wrap;
    logic               r_under;
    cap_state_e         r_state;
    cap_state_e         w_state_next;
    logic [TS_W-1:0]    r_timer;
    logic [WIDTH-1:0]   r_cap_val;
    logic [TS_W-1:0]    r_cap_time;

    logic [NUM_CMP-1:0] w_event;
    logic               w_changed;
    logic               w_wrap;
    logic               w_under;
    logic               w_cap_hit;
    logic               w_capture;
    logic               w_timer_clr;
    logic               w_timer_run;

    // Two-stage history; prev_valid marks when count_p holds a real sample, not the reset value.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_count_q    <= '0;
            r_count_p    <= '0;
            r_q_valid    <= 1'b0;
            r_prev_valid <= 1'b0;
        end else begin
            r_count_q    <= count_in;
            r_count_p    <= r_count_q;
            r_q_valid    <= 1'b1;
            r_prev_valid <= r_q_valid;
        end
    end

    assign w_changed = (r_count_q != r_count_p);
    assign w_wrap    = r_prev_valid && (&r_count_p) && (r_count_q == '0);
    assign w_under   = r_prev_valid && (r_count_p == '0) && (&r_count_q);

    always_comb begin
        w_event = '0;
        for (int unsigned i = 0; i < NUM_CMP; i++) begin
            w_event[i] = r_prev_valid && match_en[i] && w_changed &&
                         (r_count_q == match_val[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_trig   <= '0;
            r_sticky <= '0;
            r_wrap   <= 1'b0;
            r_under  <= 1'b0;
            for (int unsigned i = 0; i < NUM_CMP; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_trig   <= w_event;
            r_sticky <= w_event | (r_sticky & ~clear_flags);
            r_wrap   <= w_wrap;
            r_under  <= w_under;
            for (int unsigned i = 0; i < NUM_CMP; i++) begin
                if (clear_flags[i]) begin
                    r_cnt[i] <= w_event[i] ? CNT_W'(1) : '0;
                end else if (w_event[i] && !(&r_cnt[i])) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Out-of-range selects never match, leaving force_cap as the only capture source.
    always_comb begin
        w_cap_hit = force_cap;
        for (int unsigned i = 0; i < NUM_CMP; i++) begin
            if (cap_sel == SEL_W'(i) && w_event[i]) begin
                w_cap_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (arm) w_state_next = StArmed;
            StArmed: begin
                if (arm) begin
                    w_state_next = StArmed;
                end else if (w_cap_hit) begin
                    w_state_next = StDone;
                end
            end
            StDone:  if (arm) w_state_next = StArmed;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_timer_clr = arm;
        w_timer_run = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            StArmed: begin
                w_timer_run = 1'b1;
                w_capture   = !arm && w_cap_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_timer    <= '0;
            r_cap_val  <= '0;
            r_cap_time <= '0;
        end else begin
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (w_timer_run && !(&r_timer)) begin
                r_timer <= r_timer + TS_W'(1);
            end
            if (w_capture) begin
                r_cap_val  <= r_count_q;
                r_cap_time <= r_timer;
            end
        end
    end

    genvar g;
    for (g = 0; g < NUM_CMP; g++) begin : g_cnt_out
        assign event_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end

    assign event_trig   = r_trig;
    assign event_sticky = r_sticky;
    assign wrap_trig    = r_wrap;
    assign under_trig   = r_under;
    assign cap_state    = r_state;
    assign cap_val      = r_cap_val;
    assign cap_time     = r_cap_time;

endmodule

// File: tb/tb_count_event_monitor.sv
// Scoreboard bench for count_event_monitor: expected trigger pulses are queued with their
// cycle number and matched by a monitor; status registers are checked directly.
module tb_count_event_monitor;

    logic        sys_clk;
    logic        reset;
    logic [7:0]  count_in;
    logic [15:0] match_val;
    logic [1:0]  match_en;
    logic [1:0]  clear_flags;
    logic        arm;
    logic [0:0]  cap_sel;
    logic        force_cap;
    logic [1:0]  event_trig;
    logic [1:0]  event_sticky;
    logic [31:0] event_cnt;
    logic        wrap_trig;
    logic        under_trig;
    logic [1:0]  cap_state;
    logic [7:0]  cap_val;
    logic [23:0] cap_time;

    count_event_monitor dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .count_in     (count_in),
        .match_val    (match_val),
        .match_en     (match_en),
        .clear_flags  (clear_flags),
        .arm          (arm),
        .cap_sel      (cap_sel),
        .force_cap    (force_cap),
        .event_trig   (event_trig),
        .event_sticky (event_sticky),
        .event_cnt    (event_cnt),
        .wrap_trig    (wrap_trig),
        .under_trig   (under_trig),
        .cap_state    (cap_state),
        .cap_val      (cap_val),
        .cap_time     (cap_time)
    );

    // vec = {under, wrap, trig1, trig0}
    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        logic [3:0] obs;
        logic [3:0] exp_v;
        exp_t       e;
        obs   = {under_trig, wrap_trig, event_trig};
        exp_v = 4'b0000;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL pulse_missed: cycle %0d expected %b never seen", e.cyc, e.vec);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e     = sb.pop_front();
            exp_v = e.vec;
        end
        if (obs != 4'b0000 || exp_v != 4'b0000) begin
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL pulses @%0d: got %b expected %b", cyc, obs, exp_v);
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge sys_clk);
    endtask

    task automatic push(input int at, input logic [3:0] v);
        exp_t e;
        e.cyc = at;
        e.vec = v;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] prev;
        reset       = 1'b1;
        count_in    = 8'h00;
        match_val   = 16'h0000;
        match_en    = 2'b00;
        clear_flags = 2'b00;
        arm         = 1'b0;
        cap_sel     = 1'b0;
        force_cap   = 1'b0;
        do_reset();
        at_neg();
        chk("rst_sticky", 32'(event_sticky), 32'h0);
        chk("rst_cnt", event_cnt, 32'h0);
        chk("rst_state", 32'(cap_state), 32'h0);
        chk("rst_cap_val", 32'(cap_val), 32'h0);
        chk("rst_cap_time", 32'(cap_time), 32'h0);

        // Entry into 0x80 fires once; the repeated 0x80 does not retrigger.
        match_val[7:0] = 8'h80;
        match_en       = 2'b01;
        count_in = 8'h7E; tick(); tick(); tick();
        count_in = 8'h7F; tick();
        count_in = 8'h80; push(cyc + 2, 4'b0001); tick();
        count_in = 8'h80; tick();
        count_in = 8'h81; tick();
        tick(); tick();
        at_neg();
        chk("t1_sticky", 32'(event_sticky), 32'h1);
        chk("t1_cnt0", 32'(event_cnt[15:0]), 32'h1);
        chk("t1_cnt1", 32'(event_cnt[31:16]), 32'h0);

        // Moving the threshold onto a static count is silent; a real entry fires.
        count_in = 8'h55; tick(); tick(); tick();
        match_val[15:8] = 8'h55;
        match_en        = 2'b11;
        tick(); tick(); tick();
        count_in = 8'h56; tick();
        count_in = 8'h55; push(cyc + 2, 4'b0010); tick();
        tick(); tick(); tick();
        at_neg();
        chk("t2_cnt1", 32'(event_cnt[31:16]), 32'h1);
        chk("t2_sticky", 32'(event_sticky), 32'h3);

        // Wrap and underflow.
        count_in = 8'hFF; tick();
        count_in = 8'h00; push(cyc + 2, 4'b0100); tick();
        tick();
        count_in = 8'hFF; push(cyc + 2, 4'b1000); tick();
        tick(); tick(); tick();

        // First sample after reset must not pair with the cleared history.
        count_in = 8'hFF;
        do_reset();
        tick();
        tick();
        at_neg();
        chk("t3_no_under_after_reset", 32'(under_trig), 32'h0);
        chk("t3_rst_sticky", 32'(event_sticky), 32'h0);
        tick(); tick();

        // Saturate cnt0 by moving the threshold along with an alternating count.
        clear_flags = 2'b01; tick(); clear_flags = 2'b00;
        prev = count_in;
        for (int i = 0; i < 65540; i++) begin
            v              = i[0] ? 8'hA5 : 8'h5A;
            match_val[7:0] = prev;
            count_in       = v;
            push(cyc + 2, 4'b0001);
            prev = v;
            tick();
        end
        match_val[7:0] = prev;
        tick(); tick();
        at_neg();
        chk("t4_cnt0_sat", 32'(event_cnt[15:0]), 32'hFFFF);
        count_in = 8'h5A; push(cyc + 2, 4'b0001); tick();
        match_val[7:0] = 8'h5A;
        clear_flags    = 2'b01;
        tick();
        clear_flags = 2'b00;
        at_neg();
        chk("t4_clr_evt_sticky", 32'(event_sticky[0]), 32'h1);
        chk("t4_clr_evt_cnt0", 32'(event_cnt[15:0]), 32'h1);

        // Capture on comparator 0 after a timed wait.
        match_val[7:0] = 8'h80;
        count_in = 8'h7F; tick(); tick(); tick();
        cap_sel = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (10) tick();
        count_in = 8'h80; push(cyc + 2, 4'b0001); tick();
        tick();
        at_neg();
        chk("t5_state_done", 32'(cap_state), 32'h2);
        chk("t5_cap_val", 32'(cap_val), 32'h80);
        chk("t5_cap_time", 32'(cap_time), 32'd11);
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        at_neg();
        chk("t5_rearm_state", 32'(cap_state), 32'h1);
        chk("t5_rearm_val_held", 32'(cap_val), 32'h80);
        do_reset();
        at_neg();
        chk("t5_rst_state", 32'(cap_state), 32'h0);
        chk("t5_rst_cap_val", 32'(cap_val), 32'h0);
        chk("t5_rst_cap_time", 32'(cap_time), 32'h0);

        // Arm coinciding with a qualifying event in IDLE only arms.
        count_in = 8'h7F; tick(); tick(); tick();
        count_in = 8'h80; push(cyc + 2, 4'b0001); tick();
        arm = 1'b1; tick(); arm = 1'b0;
        at_neg();
        chk("t5_idle_arm_event", 32'(cap_state), 32'h1);
        tick(); tick();
        at_neg();
        chk("t5_static_no_capture", 32'(cap_state), 32'h1);

        // Re-arm restarts the timer; forced capture three cycles later.
        count_in = 8'h12; tick(); tick();
        arm = 1'b1; tick(); arm = 1'b0;
        tick(); tick(); tick();
        force_cap = 1'b1; tick(); force_cap = 1'b0;
        at_neg();
        chk("t6_state_done", 32'(cap_state), 32'h2);
        chk("t6_cap_val", 32'(cap_val), 32'h12);
        chk("t6_cap_time", 32'(cap_time), 32'd3);
        arm = 1'b1; tick(); arm = 1'b0;
        at_neg();
        chk("t6_rearm_state", 32'(cap_state), 32'h1);
        chk("t6_rearm_val_held", 32'(cap_val), 32'h12);
        chk("t6_rearm_time_held", 32'(cap_time), 32'd3);

        repeat (4) tick();
        at_neg();
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream consumer of the board counters; sits between a counter's value output and the WireOut/TriggerOut endpoints.
- Watches a WIDTH-bit counter value for programmable matches and for wrap/underflow.
- Produces single-cycle trigger pulses, sticky flags and saturating event counts.
- Includes an arm/capture state machine that records the counter value and the elapsed time at the first qualifying event.

Parameters:
WIDTH, 8, counter value width
NUM_CMP, 2, number of match comparators
CNT_W, 16, event counter width
TS_W, 24, capture timestamp width

Ports:
sys_clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
count_in  input  WIDTH  monitored counter value, same clock domain
match_val  input  NUM_CMP*WIDTH  comparator i threshold in bits [i*WIDTH +: WIDTH]
match_en  input  NUM_CMP  per-comparator enable
clear_flags  input  NUM_CMP  one-cycle pulse; clears sticky flag and event count i
arm  input  1  one-cycle pulse; arms the capture FSM
cap_sel  input  clog2(NUM_CMP) (min 1)  comparator that ends a capture
force_cap  input  1  one-cycle pulse; forces capture while ARMED
event_trig  output  NUM_CMP  one-cycle pulse per match entry
event_sticky  output  NUM_CMP  sticky match flags
event_cnt  output  NUM_CMP*CNT_W  saturating match counts
wrap_trig  output  1  one-cycle pulse on all-ones -> 0
under_trig  output  1  one-cycle pulse on 0 -> all-ones
cap_state  output  2  0 = IDLE, 1 = ARMED, 2 = DONE
cap_val  output  WIDTH  captured counter value
cap_time  output  TS_W  cycles from arm to capture, saturating

Behaviour:
- Reset: every output register clears to 0; FSM goes to IDLE; pipeline clears; prev_valid = 0. Reset mid-capture aborts to IDLE.
- Pipeline:
  - Each edge: count_q <= count_in; count_p <= count_q.
  - prev_valid sets on the second edge after reset.
  - count_q and count_p are compared combinationally; results are registered into the outputs.
  - Latency: a value on count_in at edge k produces its trigger pulse in the cycle after edge k+1.
- Match event i: prev_valid && match_en[i] && count_q == match_i && count_p != count_q.
  - A match fires only on entry into the value; a static count never retriggers.
  - Changing match_val onto a static count never fires.
  - match_en low suppresses the event; that comparator's sticky flag and count hold.
- wrap_trig: count_p == all-ones && count_q == 0. under_trig: count_p == 0 && count_q == all-ones. Both require prev_valid.
- Sticky flag i: set on event i, cleared by clear_flags[i]. Simultaneous set and clear -> flag = 1.
- event_cnt i: +1 per event, saturates at all-ones with no wrap; clear_flags[i] -> 0. Simultaneous event and clear -> 1.
- Capture FSM:
  - IDLE: on arm -> ARMED; timer = 0.
  - ARMED: timer increments each cycle, saturating at all-ones.
    - On event_trig[cap_sel] or force_cap -> DONE.
    - On entry to DONE: cap_val <= count_q and cap_time <= timer, both taken at the triggering edge.
    - arm while ARMED restarts the timer at 0 and stays ARMED.
  - DONE: cap_val and cap_time hold. On arm -> ARMED, with the timer cleared; cap_val and cap_time hold until the next capture.
  - Same-cycle arm and qualifying event in IDLE: arm only; the event is not captured.
  - cap_sel >= NUM_CMP: only force_cap can capture.
- All inputs are synchronous to sys_clk; no internal CDC.

Test Plan:
1. Reset, then drive count_in 0x7E, 0x7F, 0x80, 0x80, 0x81 with match0 = 0x80, en = 1 -> exactly one event_trig[0] pulse, 2 cycles after 0x80 is presented; event_sticky[0] = 1; event_cnt0 = 1.
2. Hold count_in = 0x55, then set match1 = 0x55 -> no event_trig[1]. Then step 0x56 -> 0x55 -> single pulse, event_cnt1 = 1.
3. Drive count_in 0xFF -> 0x00 -> wrap_trig pulse. Drive 0x00 -> 0xFF -> under_trig pulse. Immediately after reset, first samples 0xFF, 0x00 -> no pulse until prev_valid.
4. Preload event_cnt0 = 0xFFFF by repeated entries -> it stays 0xFFFF. Assert clear_flags[0] on the same cycle as an event -> sticky = 1, cnt = 1.
5. Pulse arm, wait 10 cycles, enter match on cap_sel = 0 at count 0x80 -> cap_state = 2, cap_val = 0x80, cap_time = cycles elapsed (deterministic, about 11). Assert reset mid-ARMED -> cap_state = 0, cap_val = 0.
6. Pulse arm, then force_cap after 3 cycles with count_in = 0x12 -> DONE, cap_val = 0x12, cap_time = 3. Re-arm -> ARMED, with the previous cap_val still held.
